// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Front-end fetch stage. Issues 2-instruction packet requests to
//            the ICache and queues responses for the instruction buffer.
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter int                       CPU_ADDR_BITS   = 32,
  parameter int                       CPU_INST_BITS   = 32,
  parameter logic [CPU_ADDR_BITS-1:0] RESET_PC        = 32'h0000_2000,
  parameter int                       MAX_OUTSTANDING = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [CPU_ADDR_BITS-1:0]   redirect_pc,
  output logic                       icache_req_val,
  output logic [CPU_ADDR_BITS-1:0]   icache_req_addr,
  input  logic                       icache_req_rdy,
  input  logic                       icache_resp_val,
  input  logic [2*CPU_INST_BITS-1:0] icache_resp_data,
  output logic [CPU_ADDR_BITS-1:0]   pc,
  output logic [2*CPU_INST_BITS-1:0] icache_dout,
  output logic                       icache_dout_val,
  input  logic                       inst_buffer_rdy
);

  localparam int c_ptr_w = $clog2(MAX_OUTSTANDING);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_tot_w = c_cnt_w + 2;
  localparam int c_pkt_w = 2 * CPU_INST_BITS;
  localparam logic [CPU_INST_BITS-1:0] c_nop      = CPU_INST_BITS'(32'h0000_0013);
  localparam logic [c_tot_w-1:0]       c_max_tot  = c_tot_w'(MAX_OUTSTANDING);
  localparam logic [c_cnt_w-1:0]       c_max_cnt  = c_cnt_w'(MAX_OUTSTANDING);
  localparam logic [CPU_ADDR_BITS-1:0] c_pkt_step = CPU_ADDR_BITS'(8);

  logic [CPU_ADDR_BITS-1:0] r_fetch_pc;
  logic [CPU_ADDR_BITS-1:0] r_resp_pc;
  logic                     r_skip_slot0;
  logic [c_cnt_w-1:0]       r_in_flight;
  logic [c_cnt_w-1:0]       r_drop_cnt;
  logic [c_cnt_w-1:0]       r_count;
  logic [c_ptr_w-1:0]       r_wr_ptr;
  logic [c_ptr_w-1:0]       r_rd_ptr;
  logic [CPU_ADDR_BITS-1:0] r_fifo_pc   [MAX_OUTSTANDING];
  logic [c_pkt_w-1:0]       r_fifo_data [MAX_OUTSTANDING];

  logic [c_tot_w-1:0]       w_total;
  logic                     w_req_val;
  logic                     w_fire;
  logic                     w_resp_drop;
  logic                     w_resp_push;
  logic                     w_pop;
  logic [CPU_ADDR_BITS-1:0] w_redirect_aligned;
  logic [c_pkt_w-1:0]       w_push_data;
  logic                     w_unused;

  // Every credit is held by an in-flight request, a pending drop or a FIFO slot,
  // so the FIFO can never overflow.
  assign w_total     = c_tot_w'(r_in_flight) + c_tot_w'(r_drop_cnt) + c_tot_w'(r_count);
  assign w_req_val   = rst_n && (w_total < c_max_tot);
  assign w_fire      = w_req_val && icache_req_rdy;
  assign w_resp_drop = icache_resp_val && (r_drop_cnt != '0);
  assign w_resp_push = icache_resp_val && (r_drop_cnt == '0);
  assign w_pop       = (r_count != '0) && inst_buffer_rdy;

  assign w_redirect_aligned = {redirect_pc[CPU_ADDR_BITS-1:3], 3'b000};
  assign w_push_data = {icache_resp_data[c_pkt_w-1:CPU_INST_BITS],
                        r_skip_slot0 ? c_nop : icache_resp_data[CPU_INST_BITS-1:0]};
  assign w_unused    = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc   <= {RESET_PC[CPU_ADDR_BITS-1:3], 3'b000};
      r_resp_pc    <= {RESET_PC[CPU_ADDR_BITS-1:3], 3'b000};
      r_skip_slot0 <= RESET_PC[2];
      r_in_flight  <= '0;
      r_drop_cnt   <= '0;
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else if (flush) begin
      // A request firing now still targets the old stream, so it joins the drops.
      r_fetch_pc   <= w_redirect_aligned;
      r_resp_pc    <= w_redirect_aligned;
      r_skip_slot0 <= redirect_pc[2];
      r_drop_cnt   <= r_drop_cnt + r_in_flight + c_cnt_w'(w_fire)
                      - c_cnt_w'(icache_resp_val);
      r_in_flight  <= '0;
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      if (w_fire) begin
        r_fetch_pc <= r_fetch_pc + c_pkt_step;
      end
      r_in_flight <= r_in_flight + c_cnt_w'(w_fire) - c_cnt_w'(w_resp_push);
      if (w_resp_drop) begin
        r_drop_cnt <= r_drop_cnt - c_cnt_w'(1);
      end
      if (w_resp_push) begin
        r_resp_pc    <= r_resp_pc + c_pkt_step;
        r_skip_slot0 <= 1'b0;
        r_wr_ptr     <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      r_count <= r_count + c_cnt_w'(w_resp_push) - c_cnt_w'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_resp_push && !flush) begin
      r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
      r_fifo_data[r_wr_ptr] <= w_push_data;
    end
  end

  assign icache_req_val  = w_req_val;
  assign icache_req_addr = r_fetch_pc;
  assign icache_dout_val = (r_count != '0);
  assign pc              = r_fifo_pc[r_rd_ptr];
  assign icache_dout     = r_fifo_data[r_rd_ptr];

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(icache_resp_val && (r_drop_cnt == '0) && (r_count == c_max_cnt)));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(icache_resp_val && (r_drop_cnt == '0) && (r_in_flight == '0)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed vectors plus a packet scoreboard for fetch_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] c_nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        icache_req_val;
  logic [31:0] icache_req_addr;
  logic        icache_req_rdy = 1'b1;
  logic        icache_resp_val = 1'b0;
  logic [63:0] icache_resp_data = '0;
  logic [31:0] pc;
  logic [63:0] icache_dout;
  logic        icache_dout_val;
  logic        inst_buffer_rdy = 1'b1;

  fetch_unit #(
    .CPU_ADDR_BITS   (32),
    .CPU_INST_BITS   (32),
    .RESET_PC        (32'h0000_2000),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .icache_req_val   (icache_req_val),
    .icache_req_addr  (icache_req_addr),
    .icache_req_rdy   (icache_req_rdy),
    .icache_resp_val  (icache_resp_val),
    .icache_resp_data (icache_resp_data),
    .pc               (pc),
    .icache_dout      (icache_dout),
    .icache_dout_val  (icache_dout_val),
    .inst_buffer_rdy  (inst_buffer_rdy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [31:0] ep; } req_t;
  typedef struct packed { logic [31:0] pc; logic [63:0] data; } pkt_t;
  typedef struct { logic ibuf; logic rv; logic [31:0] ra; logic dv; logic [31:0] dpc; } vec_t;

  req_t        resp_q[$];
  pkt_t        exp_q[$];
  logic [31:0] exp_fetch = 32'h2000;
  logic        exp_skip  = 1'b0;
  logic [31:0] epoch     = '0;
  logic        resp_en   = 1'b1;
  logic        rdy_knob  = 1'b1;
  logic        ibuf_knob = 1'b1;
  int          total = 0;
  int          bad   = 0;
  vec_t        vt[8];

  function automatic logic [63:0] mem(input logic [31:0] a);
    return {a ^ 32'hBEEF_0004, a ^ 32'hC0DE_0000};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: check outputs at the negedge, drive inputs, advance the ICache and scoreboard.
  task automatic tick(input logic fl, input logic [31:0] rpc);
    req_t r;
    req_t rq;
    pkt_t p;
    logic got, fire, pop;
    @(negedge clk);
    chk("req_val", icache_req_val, (resp_q.size() + exp_q.size()) < 2);
    if (icache_req_val) chk("req_addr", icache_req_addr, exp_fetch);
    chk("dout_val", icache_dout_val, exp_q.size() != 0);
    if (icache_dout_val && exp_q.size() != 0) begin
      chk("dout_pc", pc, exp_q[0].pc);
      chk("dout_data", icache_dout, exp_q[0].data);
    end
    flush           = fl;
    redirect_pc     = rpc;
    icache_req_rdy  = rdy_knob;
    inst_buffer_rdy = ibuf_knob;
    got = 1'b0;
    icache_resp_val  = 1'b0;
    icache_resp_data = '0;
    if (resp_en && resp_q.size() != 0) begin
      r = resp_q.pop_front();
      got = 1'b1;
      icache_resp_val  = 1'b1;
      icache_resp_data = mem(r.addr);
    end
    fire = icache_req_val && icache_req_rdy;
    pop  = icache_dout_val && inst_buffer_rdy;
    if (fire) begin
      rq.addr = icache_req_addr;
      rq.ep   = epoch;
      resp_q.push_back(rq);
    end
    if (fl) begin
      exp_q.delete();
      epoch++;
      exp_fetch = {rpc[31:3], 3'b000};
      exp_skip  = rpc[2];
    end else begin
      if (fire) exp_fetch = exp_fetch + 32'd8;
      if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
      if (got && r.ep == epoch) begin
        p.pc   = r.addr;
        p.data = mem(r.addr);
        if (exp_skip) p.data[31:0] = c_nop;
        exp_skip = 1'b0;
        exp_q.push_back(p);
      end
    end
  endtask

  initial begin
    logic found;
    vt[0] = '{1'b1, 1'b1, 32'h2000, 1'b0, 32'h0};
    vt[1] = '{1'b1, 1'b1, 32'h2008, 1'b0, 32'h0};
    vt[2] = '{1'b1, 1'b0, 32'h0,    1'b1, 32'h2000};
    vt[3] = '{1'b1, 1'b1, 32'h2010, 1'b1, 32'h2008};
    vt[4] = '{1'b1, 1'b1, 32'h2018, 1'b0, 32'h0};
    vt[5] = '{1'b1, 1'b0, 32'h0,    1'b1, 32'h2010};
    vt[6] = '{1'b1, 1'b1, 32'h2020, 1'b1, 32'h2018};
    vt[7] = '{1'b1, 1'b1, 32'h2028, 1'b0, 32'h0};

    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_req_val", icache_req_val, 1'b0);
    chk("rst_dout_val", icache_dout_val, 1'b0);
    #1 rst_n = 1'b1;

    // Steady stream from RESET_PC with a 1-cycle ICache.
    for (int i = 0; i < 8; i++) begin
      ibuf_knob = vt[i].ibuf;
      tick(1'b0, '0);
      chk("vec_req_val", icache_req_val, vt[i].rv);
      if (vt[i].rv) chk("vec_req_addr", icache_req_addr, vt[i].ra);
      chk("vec_dout_val", icache_dout_val, vt[i].dv);
      if (vt[i].dv) chk("vec_pc", pc, vt[i].dpc);
    end

    // Instruction buffer backpressure.
    ibuf_knob = 1'b0;
    for (int i = 0; i < 10; i++) tick(1'b0, '0);
    chk("bp_req_val", icache_req_val, 1'b0);
    chk("bp_dout_val", icache_dout_val, 1'b1);
    ibuf_knob = 1'b1;
    for (int i = 0; i < 8; i++) tick(1'b0, '0);

    // Flush to 0x4004 with two requests in flight.
    resp_en = 1'b0;
    for (int i = 0; i < 6; i++) tick(1'b0, '0);
    tick(1'b1, 32'h4004);
    resp_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1'b0, '0);
      if (icache_req_val) found = 1'b1;
    end
    chk("f1_req_seen", found, 1'b1);
    chk("f1_first_req", icache_req_addr, 32'h4000);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1'b0, '0);
      if (icache_dout_val) found = 1'b1;
    end
    chk("f1_out_seen", found, 1'b1);
    chk("f1_out_pc", pc, 32'h4000);
    chk("f1_out_data", icache_dout, 64'hBEEF_4004_0000_0013);

    // Flush coinciding with a request fire and a response.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1'b0, '0);
      if (resp_q.size() == 1 && exp_q.size() == 0) found = 1'b1;
    end
    chk("f2_setup", found, 1'b1);
    tick(1'b1, 32'h8000);
    tick(1'b0, '0);
    chk("f2_req_val", icache_req_val, 1'b1);
    chk("f2_req_addr", icache_req_addr, 32'h8000);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1'b0, '0);
      if (icache_dout_val) found = 1'b1;
    end
    chk("f2_out_seen", found, 1'b1);
    chk("f2_out_pc", pc, 32'h8000);
    chk("f2_out_data", icache_dout, 64'hBEEF_8004_C0DE_8000);

    // Address wrap at the top of the address space.
    tick(1'b1, 32'hFFFF_FFF8);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1'b0, '0);
      if (icache_req_val) found = 1'b1;
    end
    chk("wrap_req_seen", found, 1'b1);
    chk("wrap_first", icache_req_addr, 32'hFFFF_FFF8);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1'b0, '0);
      if (icache_req_val) found = 1'b1;
    end
    chk("wrap_next_seen", found, 1'b1);
    chk("wrap_next", icache_req_addr, 32'h0000_0000);
    for (int i = 0; i < 6; i++) tick(1'b0, '0);

    // Asynchronous reset mid-stream with packets queued.
    ibuf_knob = 1'b0;
    for (int i = 0; i < 6; i++) tick(1'b0, '0);
    chk("pre_rst_dout_val", icache_dout_val, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    icache_resp_val = 1'b0;
    flush = 1'b0;
    #1;
    chk("arst_dout_val", icache_dout_val, 1'b0);
    chk("arst_req_val", icache_req_val, 1'b0);
    resp_q.delete();
    exp_q.delete();
    epoch++;
    exp_fetch = 32'h2000;
    exp_skip  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    ibuf_knob = 1'b1;
    tick(1'b0, '0);
    chk("restart_req_val", icache_req_val, 1'b1);
    chk("restart_addr", icache_req_addr, 32'h2000);
    chk("restart_dout_val", icache_dout_val, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
